// File: rtl/intpol_mc_stream_core.sv
// intpol_mc_stream_core
//   Multichannel linear interpolator (factor L = 2^LOG2_L) between an
//   upstream FIFO and a downstream sink. One frame holds CHANNELS samples.
//   A run primes one frame into the prev registers. Each later frame is read
//   into the cur registers and produces L interpolated output frames. In
//   bypass mode each frame is read and then emitted unchanged.
//
// Ports
//   clk, rst_a          clock, asynchronous active-high reset
//   start               one-cycle run request (only accepted while idle)
//   bypass_i            pass-through mode, latched at start
//   n_frames_i          frames to consume after priming, latched at start
//   empty_i, data_i     upstream FIFO status / data (data valid cycle after rd_en_o)
//   rd_en_o             upstream FIFO read enable
//   afull_i             downstream almost-full, holds output issue
//   data_o, valid_o     registered output sample and its valid
//   busy_o, done_o      run in progress / one-cycle end-of-run pulse
//   status_o            {3'b0, bypass, stall_afull, stall_empty, busy, done_sticky}
module intpol_mc_stream_core #(
   parameter int DATA_WIDTH = 32,
   parameter int CHANNELS   = 2,
   parameter int LOG2_L     = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         rst_a,
   input  logic                         start,
   input  logic                         bypass_i,
   input  logic [CNT_WIDTH-1:0]         n_frames_i,
   input  logic                         empty_i,
   input  logic signed [DATA_WIDTH-1:0] data_i,
   output logic                         rd_en_o,
   input  logic                         afull_i,
   output logic signed [DATA_WIDTH-1:0] data_o,
   output logic                         valid_o,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [7:0]                   status_o
);

   localparam int L    = 1 << LOG2_L;
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int RC_W = $clog2(CHANNELS + 1);
   localparam int K_W  = LOG2_L + 1;
   localparam int PW   = DATA_WIDTH + 1 + LOG2_L;

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

   state_t                         state, state_nxt;
   logic                           emit_ph;      // 0: reading a frame, 1: emitting it
   logic                           bypass_r;
   logic [CNT_WIDTH-1:0]           n_frames_r;
   logic [CNT_WIDTH-1:0]           frame_cnt;
   logic [RC_W-1:0]                rd_cnt;       // reads issued in the current frame
   logic                           vld_p0;       // a read was issued last cycle
   logic [CH_W-1:0]                rd_ch_p0;     // channel of that read
   logic [CH_W-1:0]                ch_cnt;
   logic [K_W-1:0]                 k_cnt;
   logic signed [DATA_WIDTH-1:0]   prev_r [CHANNELS];
   logic signed [DATA_WIDTH-1:0]   cur_r  [CHANNELS];
   logic                           done_sticky;

   logic need, emit, issue, ch_last, k_last, frame_last, last_cap, start_ok;

   // y = prev + floor(k*(cur-prev) / L), wrapped to DATA_WIDTH. For k = L
   // the shift is exact, so the wrapped sum returns cur bit-for-bit.
   function automatic logic signed [DATA_WIDTH-1:0] interp(
      input logic signed [DATA_WIDTH-1:0] prev,
      input logic signed [DATA_WIDTH-1:0] cur,
      input logic [K_W-1:0]               k
   );
      logic signed [DATA_WIDTH:0] diff;
      logic signed [PW-1:0]       diff_x, k_x, prod, shifted;
      diff    = {cur[DATA_WIDTH-1], cur} - {prev[DATA_WIDTH-1], prev};
      diff_x  = {{LOG2_L{diff[DATA_WIDTH]}}, diff};
      k_x     = {{(PW-K_W){1'b0}}, k};
      prod    = diff_x * k_x;
      shifted = prod >>> LOG2_L;
      return prev + shifted[DATA_WIDTH-1:0];
   endfunction

   // decode of the current cycle
   always_comb begin
      need       = ((state == S_PRIME) || ((state == S_RUN) && !emit_ph)) &&
                   (rd_cnt < RC_W'(CHANNELS));
      emit       = (state == S_RUN) && emit_ph;
      issue      = emit && !afull_i;
      ch_last    = (ch_cnt == CH_W'(CHANNELS - 1));
      k_last     = bypass_r || (k_cnt == K_W'(L));
      frame_last = (frame_cnt == (n_frames_r - CNT_WIDTH'(1)));
      last_cap   = vld_p0 && (rd_ch_p0 == CH_W'(CHANNELS - 1));
      start_ok   = (state == S_IDLE) && start;
   end

   // state register
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (n_frames_i == '0) state_nxt = S_DONE;
               else if (bypass_i)    state_nxt = S_RUN;
               else                  state_nxt = S_PRIME;
            end
         end
         S_PRIME: if (last_cap) state_nxt = S_RUN;
         S_RUN:   if (issue && ch_last && k_last && frame_last) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      busy_o   = (state == S_PRIME) || (state == S_RUN);
      rd_en_o  = need && !empty_i;
      status_o = {3'b000, bypass_r, emit && afull_i, need && empty_i, busy_o, done_sticky};
   end

   // counters, sample registers and registered outputs
   always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
         emit_ph     <= 1'b0;
         bypass_r    <= 1'b0;
         n_frames_r  <= '0;
         frame_cnt   <= '0;
         rd_cnt      <= '0;
         vld_p0      <= 1'b0;
         rd_ch_p0    <= '0;
         ch_cnt      <= '0;
         k_cnt       <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         done_o      <= 1'b0;
         done_sticky <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            prev_r[i] <= '0;
            cur_r[i]  <= '0;
         end
      end else begin
         // ---- stage p0: read issue; data returns next cycle ----
         vld_p0   <= rd_en_o;
         rd_ch_p0 <= rd_cnt[CH_W-1:0];
         if (rd_en_o) rd_cnt <= rd_cnt + RC_W'(1);

         // ---- stage p1: sample capture ----
         if (vld_p0) begin
            if (state == S_PRIME) prev_r[rd_ch_p0] <= data_i;
            else                  cur_r[rd_ch_p0]  <= data_i;
         end
         if ((state == S_PRIME) && last_cap) rd_cnt <= '0;
         if ((state == S_RUN) && !emit_ph && last_cap) emit_ph <= 1'b1;

         // ---- stage p2: output issue ----
         valid_o <= issue;
         if (issue) begin
            data_o <= bypass_r ? cur_r[ch_cnt] : interp(prev_r[ch_cnt], cur_r[ch_cnt], k_cnt);
            if (ch_last) begin
               ch_cnt <= '0;
               if (k_last) begin
                  k_cnt     <= K_W'(1);
                  emit_ph   <= 1'b0;
                  rd_cnt    <= '0;
                  frame_cnt <= frame_cnt + CNT_WIDTH'(1);
                  for (int i = 0; i < CHANNELS; i++) prev_r[i] <= cur_r[i];
               end else begin
                  k_cnt <= k_cnt + K_W'(1);
               end
            end else begin
               ch_cnt <= ch_cnt + CH_W'(1);
            end
         end

         done_o <= (state == S_DONE);
         if (state == S_DONE) done_sticky <= 1'b1;

         if (start_ok) begin
            bypass_r    <= bypass_i;
            n_frames_r  <= n_frames_i;
            frame_cnt   <= '0;
            rd_cnt      <= '0;
            emit_ph     <= 1'b0;
            ch_cnt      <= '0;
            k_cnt       <= K_W'(1);
            done_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_intpol_mc_stream_core.sv
// Bench for intpol_mc_stream_core. Instance 0: CHANNELS=1, L=4.
// Instance 1: CHANNELS=2, L=2. A FIFO model feeds each instance and a
// scoreboard queue per instance holds the outputs it must produce.
module tb_intpol_mc_stream_core;

   logic               clk, rst;
   logic               start_s [2];
   logic               bypass_s [2];
   logic               empty_s [2];
   logic               afull_s [2];
   logic               rd_s [2];
   logic               valid_s [2];
   logic               busy_s [2];
   logic               done_s [2];
   logic [15:0]        nfr_s [2];
   logic signed [31:0] din_s [2];
   logic signed [31:0] dout_s [2];
   logic [7:0]         status_s [2];

   int  fifo_q [2][$];
   int  exp_q  [2][$];
   bit  hold_empty [2];
   bit  pend [2];
   int  pend_v [2];
   int  done_cnt [2];
   int  n_checks, n_errors;

   typedef struct {
      int inst;
      bit byp;
      int nfr;
      int nin;
      int fin [8];
      int nexp;
      int ex [8];
   } vec_t;
   vec_t vt [8];

   intpol_mc_stream_core #(.DATA_WIDTH(32), .CHANNELS(1), .LOG2_L(2), .CNT_WIDTH(16)) u_dut_a (
      .clk(clk), .rst_a(rst), .start(start_s[0]), .bypass_i(bypass_s[0]),
      .n_frames_i(nfr_s[0]), .empty_i(empty_s[0]), .data_i(din_s[0]), .rd_en_o(rd_s[0]),
      .afull_i(afull_s[0]), .data_o(dout_s[0]), .valid_o(valid_s[0]), .busy_o(busy_s[0]),
      .done_o(done_s[0]), .status_o(status_s[0]));

   intpol_mc_stream_core #(.DATA_WIDTH(32), .CHANNELS(2), .LOG2_L(1), .CNT_WIDTH(16)) u_dut_b (
      .clk(clk), .rst_a(rst), .start(start_s[1]), .bypass_i(bypass_s[1]),
      .n_frames_i(nfr_s[1]), .empty_i(empty_s[1]), .data_i(din_s[1]), .rd_en_o(rd_s[1]),
      .afull_i(afull_s[1]), .data_o(dout_s[1]), .valid_o(valid_s[1]), .busy_o(busy_s[1]),
      .done_o(done_s[1]), .status_o(status_s[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   // floor(k*(c-p)/2^lg) added to p, wrapped to 32 bits
   function automatic int model_y(input int p, input int c, input int k, input int lg);
      longint d, prod, q, l;
      d    = longint'(c) - longint'(p);
      prod = d * k;
      l    = longint'(1) << lg;
      q    = prod / l;
      if ((prod % l != 0) && (prod < 0)) q = q - 1;
      return int'(longint'(p) + q);
   endfunction

   task automatic refresh_empty();
      for (int g = 0; g < 2; g++) empty_s[g] = (fifo_q[g].size() == 0) || hold_empty[g];
   endtask

   // One clock: sample read requests before the edge, then on the falling
   // edge deliver read data, update empty and score any output sample.
   task automatic tick();
      #2;
      for (int g = 0; g < 2; g++) begin
         if (rd_s[g]) begin
            check($sformatf("rd_while_empty[%0d]", g), empty_s[g], 0);
            if (fifo_q[g].size() > 0) begin
               pend_v[g] = fifo_q[g].pop_front();
               pend[g]   = 1'b1;
            end
         end
      end
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         if (pend[g]) begin
            din_s[g] = pend_v[g];
            pend[g]  = 1'b0;
         end
      end
      refresh_empty();
      for (int g = 0; g < 2; g++) begin
         if (valid_s[g]) begin
            n_checks++;
            if (exp_q[g].size() == 0) begin
               n_errors++;
               $display("FAIL sb_extra[%0d]: got %0d, required no output", g, dout_s[g]);
            end else begin
               int e;
               e = exp_q[g].pop_front();
               if (dout_s[g] != e) begin
                  n_errors++;
                  $display("FAIL sb_out[%0d]: got %0d, required %0d", g, dout_s[g], e);
               end
            end
         end
         if (done_s[g]) done_cnt[g]++;
      end
   endtask

   task automatic pulse_start(input int g, input bit byp, input int nfr);
      bypass_s[g] = byp;
      nfr_s[g]    = 16'(nfr);
      start_s[g]  = 1'b1;
      tick();
      start_s[g]  = 1'b0;
   endtask

   task automatic wait_done(input int g, input string nm);
      int d0;
      d0 = done_cnt[g];
      for (int i = 0; i < 300 && done_cnt[g] == d0; i++) tick();
      check({nm, "_done_seen"}, done_cnt[g] - d0, 1);
      check({nm, "_outs_left"}, exp_q[g].size(), 0);
      check({nm, "_fifo_left"}, fifo_q[g].size(), 0);
      check({nm, "_sticky"}, status_s[g][0], 1);
      tick();
      check({nm, "_idle_busy"}, busy_s[g], 0);
   endtask

   task automatic wait_valid(input int g, input string nm);
      for (int i = 0; i < 100 && !valid_s[g]; i++) tick();
      check({nm, "_valid_seen"}, valid_s[g], 1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         start_s[g] = 0; bypass_s[g] = 0; afull_s[g] = 0; nfr_s[g] = 0;
         din_s[g] = 0; hold_empty[g] = 0; pend[g] = 0; done_cnt[g] = 0;
      end
      refresh_empty();

      vt[0] = '{0, 0, 1, 2, '{0, 8, 0, 0, 0, 0, 0, 0}, 4, '{2, 4, 6, 8, 0, 0, 0, 0}};
      vt[1] = '{0, 0, 1, 2, '{8, -8, 0, 0, 0, 0, 0, 0}, 4, '{4, 0, -4, -8, 0, 0, 0, 0}};
      vt[2] = '{0, 0, 1, 2, '{0, -1, 0, 0, 0, 0, 0, 0}, 4, '{-1, -1, -1, -1, 0, 0, 0, 0}};
      vt[3] = '{1, 0, 1, 4, '{0, 100, 10, 200, 0, 0, 0, 0}, 4, '{5, 150, 10, 200, 0, 0, 0, 0}};
      vt[4] = '{1, 1, 2, 4, '{1, -2, 3, -4, 0, 0, 0, 0}, 4, '{1, -2, 3, -4, 0, 0, 0, 0}};
      vt[5] = '{0, 0, 2, 3, '{0, 4, -4, 0, 0, 0, 0, 0}, 8, '{1, 2, 3, 4, 2, 0, -2, -4}};
      vt[6] = '{0, 0, 1, 2, '{32'sh7FFFFFFF, 32'sh80000000, 0, 0, 0, 0, 0, 0}, 4,
                '{1073741823, -1, -1073741825, 32'sh80000000, 0, 0, 0, 0}};
      vt[7] = '{0, 0, 0, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, '{0, 0, 0, 0, 0, 0, 0, 0}};

      // reset state
      tick();
      tick();
      check("rst_rd_en", rd_s[0], 0);
      check("rst_valid", valid_s[0], 0);
      check("rst_data", dout_s[0], 0);
      check("rst_busy", busy_s[0], 0);
      check("rst_done", done_s[0], 0);
      check("rst_status_a", status_s[0], 0);
      check("rst_status_b", status_s[1], 0);
      rst = 1'b0;

      // table-driven runs
      for (int i = 0; i < 8; i++) begin
         int g;
         g = vt[i].inst;
         for (int j = 0; j < vt[i].nin; j++)  fifo_q[g].push_back(vt[i].fin[j]);
         for (int j = 0; j < vt[i].nexp; j++) exp_q[g].push_back(vt[i].ex[j]);
         refresh_empty();
         pulse_start(g, vt[i].byp, vt[i].nfr);
         wait_done(g, $sformatf("vec%0d", i));
      end

      // consecutive outputs, done right after the last one, start ignored while busy
      fifo_q[0].push_back(0); fifo_q[0].push_back(8);
      exp_q[0].push_back(2); exp_q[0].push_back(4); exp_q[0].push_back(6); exp_q[0].push_back(8);
      refresh_empty();
      pulse_start(0, 0, 1);
      wait_valid(0, "seq030");
      bypass_s[0] = 1'b1;
      start_s[0]  = 1'b1;
      tick();
      start_s[0]  = 1'b0;
      bypass_s[0] = 1'b0;
      check("seq030_consec2", valid_s[0], 1);
      tick();
      check("seq030_consec3", valid_s[0], 1);
      tick();
      check("seq030_consec4", valid_s[0], 1);
      tick();
      check("seq030_done", done_s[0], 1);
      check("seq030_valid_after", valid_s[0], 0);
      check("seq030_outs_left", exp_q[0].size(), 0);
      tick();
      tick();
      check("seq030_no_rerun", busy_s[0], 0);

      // downstream stall for three cycles
      fifo_q[1] = '{0, 100, 10, 200};
      exp_q[1]  = '{5, 150, 10, 200};
      refresh_empty();
      pulse_start(1, 0, 1);
      check("seq033_sticky_clr", status_s[1][0], 0);
      check("seq033_busy", busy_s[1], 1);
      wait_valid(1, "seq033");
      afull_s[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("seq033_valid_low%0d", i), valid_s[1], 0);
         check($sformatf("seq033_stall_afull%0d", i), status_s[1][3], 1);
      end
      afull_s[1] = 1'b0;
      wait_done(1, "seq033");

      // bypass with an initially empty upstream FIFO
      hold_empty[1] = 1'b1;
      fifo_q[1] = '{7, -7, 70, -70};
      exp_q[1]  = '{7, -7, 70, -70};
      refresh_empty();
      pulse_start(1, 1, 2);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("seq034_rd_low%0d", i), rd_s[1], 0);
         check($sformatf("seq034_stall_empty%0d", i), status_s[1][2], 1);
         check($sformatf("seq034_bypass_flag%0d", i), status_s[1][4], 1);
         tick();
      end
      hold_empty[1] = 1'b0;
      refresh_empty();
      wait_done(1, "seq034");

      // random interpolation run against the reference model
      begin : rnd
         int p [2];
         int c [2];
         for (int ch = 0; ch < 2; ch++) begin
            p[ch] = $urandom;
            fifo_q[1].push_back(p[ch]);
         end
         for (int f = 0; f < 3; f++) begin
            for (int ch = 0; ch < 2; ch++) begin
               c[ch] = $urandom;
               fifo_q[1].push_back(c[ch]);
            end
            for (int k = 1; k <= 2; k++)
               for (int ch = 0; ch < 2; ch++) exp_q[1].push_back(model_y(p[ch], c[ch], k, 1));
            p = c;
         end
         refresh_empty();
         pulse_start(1, 0, 3);
         wait_done(1, "rnd");
      end

      // reset in the middle of a run, then a clean run right after release
      fifo_q[0] = '{0, 8};
      exp_q[0]  = '{2, 4, 6, 8};
      refresh_empty();
      pulse_start(0, 0, 1);
      wait_valid(0, "seq035");
      rst = 1'b1;
      #1;
      check("seq035_rd_en", rd_s[0], 0);
      check("seq035_data", dout_s[0], 0);
      check("seq035_valid", valid_s[0], 0);
      check("seq035_busy", busy_s[0], 0);
      check("seq035_done", done_s[0], 0);
      check("seq035_status", status_s[0], 0);
      fifo_q[0].delete();
      exp_q[0].delete();
      pend[0] = 1'b0;
      tick();
      rst = 1'b0;
      fifo_q[0] = '{0, 8};
      exp_q[0]  = '{2, 4, 6, 8};
      refresh_empty();
      pulse_start(0, 0, 1);
      wait_done(0, "seq035_rerun");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/intpol_mc_stream_core.md
INTPOL_MC_STREAM_CORE -- requirements
Module: intpol_mc_stream_core

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_WIDTH, 32, signed sample width; CHANNELS, 2, interleaved channel count (1..8); LOG2_L, 2, interpolation factor L=2^LOG2_L (1..4); CNT_WIDTH, 16, frame counter width.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_a  in  1  asynchronous reset, active-high.
REQ-004 start  in  1  one-cycle run request.
REQ-005 bypass_i  in  1  1 = pass samples through without interpolation; sampled at start.
REQ-006 n_frames_i  in  CNT_WIDTH  input frames (CHANNELS samples each) to process after priming; sampled at start.
REQ-007 empty_i  in  1  upstream FIFO empty.
REQ-008 data_i  in  DATA_WIDTH  signed FIFO output, valid the cycle after rd_en_o.
REQ-009 rd_en_o  out  1  FIFO read enable.
REQ-010 afull_i  in  1  downstream almost-full; stalls output.
REQ-011 data_o  out  DATA_WIDTH  signed output sample.
REQ-012 valid_o  out  1  data_o valid this cycle.
REQ-013 busy_o  out  1  run in progress.
REQ-014 done_o  out  1  one-cycle pulse at run end.
REQ-015 status_o  out  8  {3'b0, bypass, stall_afull, stall_empty, busy, done_sticky}.

Function
REQ-016 FSM states SHALL be IDLE, PRIME, RUN, DONE; start in IDLE latches bypass_i and n_frames_i; start outside IDLE SHALL be ignored.
REQ-017 IDLE->PRIME on start with n_frames_i>0 and bypass 0; IDLE->RUN with bypass 1; IDLE->DONE if n_frames_i=0 (no reads, no outputs).
REQ-018 PRIME reads one frame into per-channel prev registers (channel index 0..CHANNELS-1 in read order), no output, then RUN.
REQ-019 RUN interpolating: per input frame, read CHANNELS samples into cur registers, then emit L output frames, k=1..L, each frame channels 0..CHANNELS-1, y = prev + ((k*(cur-prev)) >>> LOG2_L); then prev<=cur.
REQ-020 Arithmetic: difference in DATA_WIDTH+1 bits, product in DATA_WIDTH+1+LOG2_L bits, arithmetic shift (floor), sum truncated to DATA_WIDTH; k=L SHALL yield exactly cur.
REQ-021 RUN bypass: each read sample emitted unchanged, order preserved, n_frames*CHANNELS outputs total.
REQ-022 Output is registered: at most one sample per cycle; valid_o=1 only when afull_i=0 in the preceding issue cycle; while afull_i=1 no new output is issued and all indices hold.
REQ-023 rd_en_o=1 only when a sample is needed and empty_i=0; no read SHALL be issued while empty_i=1; reads and emits of successive frames do not overlap (reads first, then L*CHANNELS emits).
REQ-024 stall_empty=1 while a sample is needed and empty_i=1; stall_afull=1 while an output is pending and afull_i=1.
REQ-025 Run ends after n_frames frames consumed in RUN; interpolating outputs = n_frames*L*CHANNELS; last valid_o followed next cycle by DONE, done_o=1 one cycle, then IDLE.
REQ-026 done_sticky set by done_o, cleared by next accepted start; busy_o=1 in PRIME and RUN.
REQ-027 Simultaneous empty_i and afull_i: each gate acts independently on its own path.

Reset
REQ-028 rst_a=1 at any time SHALL force IDLE and zero rd_en_o, data_o, valid_o, busy_o, done_o, status_o, counters, prev/cur registers within the same cycle, mid-run included.
REQ-029 After rst_a deassert the block SHALL accept start on the first clock edge.

Verification
REQ-030 CHANNELS=1, L=4, n_frames=1, FIFO 0,8 -> outputs 2,4,6,8 on consecutive cycles, then done_o.
REQ-031 CHANNELS=1, L=4, FIFO 8,-8 -> outputs 4,0,-4,-8; FIFO 0,-1 -> -1,-1,-1,-1 (floor).
REQ-032 CHANNELS=2, L=2, n_frames=1, FIFO 0,100,10,200 -> 5,150,10,200.
REQ-033 afull_i high 3 cycles mid-run -> valid_o low those cycles, no sample lost/duplicated, stall_afull=1.
REQ-034 bypass=1, n_frames=2, CHANNELS=2, FIFO empty first 4 cycles -> rd_en_o low, stall_empty=1, then 4 samples out unchanged, done_o.
REQ-035 rst_a pulse during RUN -> all outputs 0 same cycle; new start runs REQ-030 correctly.
